// File: rtl/gzip_bit_packer_pkg.sv
// Shared gzip definitions: accumulator/word widths, packer FSM states and the
// code-length mask helper.
package gzip_bit_packer_pkg;

    localparam int unsigned ACC_WIDTH = 64;
    localparam int unsigned OUT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // len is already saturated to 0..32
    function automatic logic [31:0] len_mask(input logic [6:0] len);
        if (len >= 7'd32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'h1 << len[4:0]) - 32'h1;
    endfunction

endpackage

// File: rtl/gzip_bit_packer.sv
// Packs LSB-first variable-length deflate codes into 32-bit FIFO words, with
// zero-padded flush at end of block and a running count of words written.
module gzip_bit_packer
    import gzip_bit_packer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH  = 6,
    parameter int unsigned WCNT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  code_valid,
    input  logic [31:0]           code_data,
    input  logic [LEN_WIDTH-1:0]  code_len,
    output logic                  code_ready,
    input  logic                  flush,
    output logic                  flush_done,
    input  logic                  fifo_full,
    output logic                  wr_en_fifo_out,
    output logic [OUT_WIDTH-1:0]  din_fifo_out,
    output logic [WCNT_WIDTH-1:0] word_count
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [6:0]           cnt_q, cnt_d;
    state_e               state_q;

    logic       fire;
    logic       emit;
    logic [6:0] len_sat;
    logic [6:0] sh;
    logic [31:0] data_m;

    assign code_ready     = (state_q == ST_RUN) && (cnt_q <= 7'd32);
    assign fire           = code_valid && code_ready;
    assign emit           = !fifo_full &&
                            ((cnt_q >= 7'd32) || ((state_q == ST_FLUSH) && (cnt_q != 7'd0)));
    assign wr_en_fifo_out = emit;
    // Bits above cnt are always zero, so a flushed partial word is already padded.
    assign din_fifo_out   = acc_q[OUT_WIDTH-1:0];
    assign flush_done     = (state_q == ST_DONE);

    always_comb begin
        len_sat = (code_len > LEN_WIDTH'(32)) ? 7'd32 : 7'(code_len);
        data_m  = code_data & len_mask(len_sat);
        sh      = 7'd0;
        if (emit) begin
            sh = (cnt_q >= 7'd32) ? 7'd32 : cnt_q;
        end
        acc_d = acc_q >> sh;
        cnt_d = cnt_q - sh;
        if (fire) begin
            // fire implies cnt<=32, so the new bits always fit in 64 bits
            acc_d = acc_d | ({32'b0, data_m} << (cnt_q - sh));
            cnt_d = cnt_d + len_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            word_count <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (emit) begin
                word_count <= word_count + 1'b1;
            end
            unique case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 7'd0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_gzip_bit_packer.sv
// Bench for gzip_bit_packer: directed cases plus random beats checked against a
// bit-queue reference model.
module tb_gzip_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        code_valid;
    logic [31:0] code_data;
    logic [5:0]  code_len;
    logic        code_ready;
    logic        flush;
    logic        flush_done;
    logic        fifo_full;
    logic        wr_en_fifo_out;
    logic [31:0] din_fifo_out;
    logic [23:0] word_count;

    gzip_bit_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .code_valid     (code_valid),
        .code_data      (code_data),
        .code_len       (code_len),
        .code_ready     (code_ready),
        .flush          (flush),
        .flush_done     (flush_done),
        .fifo_full      (fifo_full),
        .wr_en_fifo_out (wr_en_fifo_out),
        .din_fifo_out   (din_fifo_out),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          model_bits[$];
    logic [31:0] exp_words[$];
    logic [23:0] model_wc;
    logic [31:0] last_word;
    bit          rand_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a plain bit stream cut into 32-bit words.
    task automatic model_push(input logic [31:0] d, input int l);
        int n = (l > 32) ? 32 : l;
        logic [31:0] w;
        for (int i = 0; i < n; i++) model_bits.push_back(d[i]);
        while (model_bits.size() >= 32) begin
            for (int i = 0; i < 32; i++) w[i] = model_bits.pop_front();
            exp_words.push_back(w);
            model_wc++;
        end
    endtask

    task automatic model_flush();
        if (model_bits.size() > 0) begin
            while (model_bits.size() < 32) model_bits.push_back(1'b0);
            model_push(32'h0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fifo_full) begin
                check("no_write_while_full", 64'(wr_en_fifo_out), 64'd0);
            end else if (wr_en_fifo_out) begin
                check("write_was_expected", 64'(exp_words.size() != 0), 64'd1);
                if (exp_words.size() != 0) begin
                    check("write_data", 64'(din_fifo_out), 64'(exp_words.pop_front()));
                end
                last_word = din_fifo_out;
            end
        end
    end

    task automatic send(input logic [31:0] d, input int l);
        bit done = 1'b0;
        int waited = 0;
        @(posedge clk); #1;
        code_valid = 1'b1;
        code_data  = d;
        code_len   = 6'(l);
        if (rand_mode) fifo_full = ($urandom_range(0, 3) == 0);
        while (!done) begin
            @(negedge clk);
            if (code_ready) begin
                model_push(d, l);
                done = 1'b1;
            end else if (waited > 64) begin
                check("send_accepted", 64'(code_ready), 64'd1);
                done = 1'b1;
            end else begin
                waited++;
                @(posedge clk); #1;
                if (rand_mode) fifo_full = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        code_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_flush();
        bit seen = 1'b0;
        @(posedge clk); #1;
        code_valid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        model_flush();
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (flush_done) seen = 1'b1;
            else if (rand_mode) begin
                @(posedge clk); #1;
                fifo_full = ($urandom_range(0, 2) == 0);
            end
        end
        check("flush_done_seen", 64'(seen), 64'd1);
        check("all_words_written", 64'(exp_words.size()), 64'd0);
        check("word_count", 64'(word_count), 64'(model_wc));
        @(negedge clk);
        check("flush_done_one_cycle", 64'(flush_done), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n      = 1'b0;
        code_valid = 1'b0;
        flush      = 1'b0;
        model_bits.delete();
        exp_words.delete();
        model_wc = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_wr_en", 64'(wr_en_fifo_out), 64'd0);
        check("rst_din", 64'(din_fifo_out), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_code_ready", 64'(code_ready), 64'd1);
        check("rst_word_count", 64'(word_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_data  = '0;
        code_len   = '0;
        flush      = 1'b0;
        fifo_full  = 1'b0;
        model_wc   = '0;
        last_word  = '0;
        apply_reset();

        // 1: three 9-bit codes then flush
        send(32'h1A5, 9);
        send(32'h0F3, 9);
        send(32'h155, 9);
        do_flush();
        check("t1_word", 64'(last_word), 64'h0555_E7A5);
        check("t1_word_count", 64'(word_count), 64'd1);

        // 2: two full words back to back
        send(32'hDEAD_BEEF, 32);
        send(32'h1234_5678, 32);
        idle(4);
        check("t2_last_word", 64'(last_word), 64'h1234_5678);
        check("t2_drained", 64'(exp_words.size()), 64'd0);

        // 3: straddle
        send(32'h3FFF_FFFF, 30);
        send(32'hA, 4);
        do_flush();
        check("t3_last_word", 64'(last_word), 64'h2);

        // 4: masking, then empty flush
        send(32'hFFFF_FFFF, 3);
        do_flush();
        check("t4_masked_word", 64'(last_word), 64'h7);
        do_flush();

        // 5: backpressure
        fifo_full = 1'b1;
        send(32'hCAFE_F00D, 32);
        send(32'h5A, 8);
        idle(1);
        @(negedge clk);
        check("t5_ready_low", 64'(code_ready), 64'd0);
        repeat (10) @(posedge clk);
        #1 fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        check("t5_first_word", 64'(last_word), 64'hCAFE_F00D);
        do_flush();
        check("t5_pad_word", 64'(last_word), 64'h5A);

        // 6: reset mid-block drops buffered bits
        send(32'hFFFFF, 20);
        idle(1);
        apply_reset();
        do_flush();
        check("t6_word_count", 64'(word_count), 64'd0);

        // 7: random beats, lengths incl. >32, random backpressure and flushes
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send($urandom, int'($urandom_range(0, 40)));
            if ($urandom_range(0, 24) == 0) do_flush();
        end
        do_flush();
        rand_mode = 1'b0;
        fifo_full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
